axi_lite_master: RTL

Single-outstanding AXI4-Lite initiator. It turns a simple req/gnt memory-style request port into AXI transactions on an `ariane_axi` request/response struct pair. It is the initiator-side counterpart of the CLINT-style AXI-lite slave: cores and debug or DMA helpers use it to reach AXI-lite peripherals without handling AXI channel handshakes themselves. Exactly one transaction is in flight at a time.

---
 rtl/axi_lite_master.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator.
// Converts a req/gnt memory-style request into one AXI-lite write (AW+W, B)
// or read (AR, R) transaction at a time on the ariane_axi struct pair.

package ariane_axi;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 10;
  localparam int unsigned UserWidth = 1;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_lite_master #(
  parameter int unsigned             AXI_ADDR_WIDTH = 64,
  parameter int unsigned             AXI_DATA_WIDTH = 64,
  parameter int unsigned             AXI_ID_WIDTH   = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = {AXI_ID_WIDTH{1'b0}}
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  output logic                        gnt_o,
  output logic                        done_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output ariane_axi::req_t            axi_req_o,
  input  ariane_axi::resp_t           axi_resp_i
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  // Every beat is a full-width transfer.
  localparam logic [2:0]  AXI_SIZE   = 3'($clog2(STRB_WIDTH));
  localparam logic [1:0]  BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WAIT_B = 3'd2,
    READ   = 3'd3,
    WAIT_R = 3'd4
  } state_e;

  state_e                    state_r, state_s;
  logic                      aw_pend_r, aw_pend_s;
  logic                      w_pend_r, w_pend_s;
  logic                      ar_valid_r;
  logic                      b_ready_r;
  logic                      r_ready_r;
  logic [AXI_ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [AXI_DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic [STRB_WIDTH-1:0]     be_r, be_s;
  logic                      done_r, done_s;
  logic                      err_r, err_s;
  logic [AXI_DATA_WIDTH-1:0] rdata_r, rdata_s;
  logic                      gnt_s;
  logic                      unused_resp_s;

  // Response fields this initiator never looks at (IDs, last, user).
  assign unused_resp_s = ^{axi_resp_i.b.id, axi_resp_i.b.user, axi_resp_i.b.resp[0],
                           axi_resp_i.r.id, axi_resp_i.r.user, axi_resp_i.r.last,
                           axi_resp_i.r.resp[0]};

  // Next-state, grant and completion decode for the single in-flight transaction.
  always_comb begin
    state_s   = state_r;
    aw_pend_s = aw_pend_r;
    w_pend_s  = w_pend_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    be_s      = be_r;
    done_s    = 1'b0;
    err_s     = err_r;
    rdata_s   = rdata_r;
    gnt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        gnt_s = req_i;
        if (req_i) begin
          addr_s  = addr_i;
          wdata_s = wdata_i;
          be_s    = be_i;
          if (we_i) begin
            state_s   = WRITE;
            aw_pend_s = 1'b1;
            w_pend_s  = 1'b1;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        // AW and W complete independently; move on once neither is pending.
        if (aw_pend_r && axi_resp_i.aw_ready) begin
          aw_pend_s = 1'b0;
        end else begin
          aw_pend_s = aw_pend_r;
        end
        if (w_pend_r && axi_resp_i.w_ready) begin
          w_pend_s = 1'b0;
        end else begin
          w_pend_s = w_pend_r;
        end
        if (!aw_pend_s && !w_pend_s) begin
          state_s = WAIT_B;
        end else begin
          state_s = WRITE;
        end
      end
      WAIT_B: begin
        if (axi_resp_i.b_valid) begin
          done_s  = 1'b1;
          err_s   = axi_resp_i.b.resp[1];
          state_s = IDLE;
        end else begin
          state_s = WAIT_B;
        end
      end
      READ: begin
        if (axi_resp_i.ar_ready) begin
          state_s = WAIT_R;
        end else begin
          state_s = READ;
        end
      end
      WAIT_R: begin
        if (axi_resp_i.r_valid) begin
          done_s  = 1'b1;
          err_s   = axi_resp_i.r.resp[1];
          rdata_s = axi_resp_i.r.data;
          state_s = IDLE;
        end else begin
          state_s = WAIT_R;
        end
      end
      default: begin
        state_s   = IDLE;
        aw_pend_s = 1'b0;
        w_pend_s  = 1'b0;
      end
    endcase
  end

  // State, handshake flags and result registers; async reset drops all valids at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      aw_pend_r  <= 1'b0;
      w_pend_r   <= 1'b0;
      ar_valid_r <= 1'b0;
      b_ready_r  <= 1'b0;
      r_ready_r  <= 1'b0;
      addr_r     <= {AXI_ADDR_WIDTH{1'b0}};
      wdata_r    <= {AXI_DATA_WIDTH{1'b0}};
      be_r       <= {STRB_WIDTH{1'b0}};
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= {AXI_DATA_WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      aw_pend_r  <= aw_pend_s;
      w_pend_r   <= w_pend_s;
      ar_valid_r <= (state_s == READ);
      b_ready_r  <= (state_s == WAIT_B);
      r_ready_r  <= (state_s == WAIT_R);
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      be_r       <= be_s;
      done_r     <= done_s;
      err_r      <= err_s;
      rdata_r    <= rdata_s;
    end
  end

  // Drive the AXI channels from registered flags and latched request fields only.
  always_comb begin
    axi_req_o             = {$bits(ariane_axi::req_t){1'b0}};
    axi_req_o.aw.id       = AXI_ID;
    axi_req_o.aw.addr     = addr_r;
    axi_req_o.aw.len      = 8'd0;
    axi_req_o.aw.size     = AXI_SIZE;
    axi_req_o.aw.burst    = BURST_INCR;
    axi_req_o.aw_valid    = aw_pend_r;
    axi_req_o.w.data      = wdata_r;
    axi_req_o.w.strb      = be_r;
    axi_req_o.w.last      = 1'b1;
    axi_req_o.w_valid     = w_pend_r;
    axi_req_o.b_ready     = b_ready_r;
    axi_req_o.ar.id       = AXI_ID;
    axi_req_o.ar.addr     = addr_r;
    axi_req_o.ar.len      = 8'd0;
    axi_req_o.ar.size     = AXI_SIZE;
    axi_req_o.ar.burst    = BURST_INCR;
    axi_req_o.ar_valid    = ar_valid_r;
    axi_req_o.r_ready     = r_ready_r;
  end

  assign gnt_o   = gnt_s;
  assign done_o  = done_r;
  assign err_o   = err_r;
  assign rdata_o = rdata_r;

endmodule
